mouse_receiver: RTL and testbench
=================================

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 50000, max CLK cycles allowed between consecutive PS/2 clock falling edges inside a frame.
REQ-002 Parameter SYNC_STAGES, 2, flip-flop depth of the input synchronisers on CLK_MOUSE_IN and DATA_MOUSE_IN.
REQ-003 CLK  input  1  system clock; every flop in the block sits on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 CLK_MOUSE_IN  input  1  PS/2 clock line, sampled raw from the open-drain pad.
REQ-006 DATA_MOUSE_IN  input  1  PS/2 data line, sampled raw from the open-drain pad.
REQ-007 READ_ENABLE  input  1  high = frame reception permitted; held low by the transmitter while it drives the lines.
REQ-008 BYTE_READ  output  1  one-cycle pulse: a complete frame was received.
REQ-009 BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error, for the frame flagged by BYTE_READ.
REQ-010 BYTE  output  8  received data byte, LSB first on the wire.
REQ-011 BUSY  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-012 Both PS/2 inputs pass through SYNC_STAGES flops; a falling edge = previous synced clock 1, current synced clock 0; all sampling uses the synced data on that edge only.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP, DONE.
REQ-014 IDLE: on falling edge with READ_ENABLE=1 and synced data=0 (start bit) -> DATA, bit counter cleared; edge with data=1 or READ_ENABLE=0 ignored.
REQ-015 DATA: each falling edge shifts data into a shift register from the MSB side (LSB arrives first); after the 8th bit -> PARITY.
REQ-016 PARITY: on the falling edge, capture the parity bit; parity error = XOR of 8 data bits and parity bit equals 0 (odd parity required) -> STOP.
REQ-017 STOP: on the falling edge, stop error = sampled bit equals 0 -> DONE.
REQ-018 DONE: lasts exactly one cycle; BYTE, BYTE_ERROR_CODE update and BYTE_READ=1 in this cycle -> IDLE.
REQ-019 Latency: BYTE_READ asserts 2 CLK cycles after the cycle in which the stop-bit falling edge is detected on the synced clock.
REQ-020 Errors never suppress BYTE_READ; the byte is delivered with its error code and the consumer decides.
REQ-021 BYTE and BYTE_ERROR_CODE hold their values until the next DONE.
REQ-022 Timeout counter clears on every detected falling edge and in IDLE; counts otherwise; reaching TIMEOUT_CYCLES in any non-IDLE state -> IDLE, no BYTE_READ, outputs unchanged.
REQ-023 READ_ENABLE falling mid-frame aborts immediately -> IDLE, no BYTE_READ, outputs unchanged.
REQ-024 Timeout and falling edge in the same cycle: edge wins, counter clears.
REQ-025 Timeout counter width = clog2(TIMEOUT_CYCLES+1); it saturates, never wraps.

Reset
REQ-026 RESET forces state IDLE, BYTE=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READ=0, BUSY=0, counters 0, synchroniser flops 1 (idle bus level).
REQ-027 RESET asserted mid-frame discards the partial frame; first frame accepted requires a fresh start bit after release.

Structure
REQ-028 Shared package ps2_pkg holds the FSM state encoding, error-code bit positions and default TIMEOUT_CYCLES.
REQ-029 One sub-module, ps2_edge_sync, containing the synchronisers and falling-edge detector; reused by the transmitter.

Verification
REQ-030 Frame byte 8'h08, parity 0, stop 1 -> one BYTE_READ pulse, BYTE=8'h08, BYTE_ERROR_CODE=2'b00.
REQ-031 Frame byte 8'hFA with parity 0 (wrong) -> BYTE=8'hFA, BYTE_ERROR_CODE=2'b01.
REQ-032 Frame byte 8'h00, parity 1, stop bit 0 -> BYTE=8'h00, BYTE_ERROR_CODE=2'b10.
REQ-033 5 bits sent then clock held high > TIMEOUT_CYCLES -> no BYTE_READ, BUSY drops; following full frame 8'hAA decoded correctly.
REQ-034 READ_ENABLE=0 during a complete frame -> no BYTE_READ, BUSY stays 0; RESET pulse mid-frame -> outputs return to reset values, next frame 8'h55 decoded.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error-code bit positions and
// default timing parameters used by the receiver and transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4
    } ps2_state_e;

    localparam int ERR_PARITY_BIT         = 0;
    localparam int ERR_STOP_BIT           = 1;
    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;
    localparam int SYNC_STAGES_DEFAULT    = 2;

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronises the raw PS/2 clock and data pads into the system clock domain
// and flags falling edges of the synchronised PS/2 clock.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = ps2_pkg::SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic ps2_clk_sync,
    output logic ps2_data_sync,
    output logic ps2_clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d     = clk_sync_q;
        data_sync_d    = data_sync_q;
        clk_sync_d[0]  = ps2_clk_in;
        data_sync_d[0] = ps2_data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_d[i]  = clk_sync_q[i-1];
            data_sync_d[i] = data_sync_q[i-1];
        end
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle bus level so releasing reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign ps2_clk_sync  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_sync = data_sync_q[SYNC_STAGES-1];
    assign ps2_clk_fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity,
// stop. Delivers every complete frame with a parity/stop error code.
module mouse_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic       BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic [7:0] BYTE,
    output logic       BUSY
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic ps2_clk_sync;
    logic ps2_data_sync;
    logic ps2_clk_fall;

    ps2_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk          (CLK),
        .rst          (RESET),
        .ps2_clk_in   (CLK_MOUSE_IN),
        .ps2_data_in  (DATA_MOUSE_IN),
        .ps2_clk_sync (ps2_clk_sync),
        .ps2_data_sync(ps2_data_sync),
        .ps2_clk_fall (ps2_clk_fall)
    );

    ps2_state_e      state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            parity_err_q, parity_err_d;
    logic            stop_err_q, stop_err_d;
    logic [7:0]      byte_q, byte_d;
    logic [1:0]      err_q, err_d;
    logic            byte_read_q, byte_read_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic timeout;
    logic abort;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_err_d = parity_err_q;
        stop_err_d   = stop_err_q;
        byte_d       = byte_q;
        err_d        = err_q;
        byte_read_d  = 1'b0;
        to_cnt_d     = to_cnt_q;

        timeout = (to_cnt_q == TO_MAX);
        // A falling edge in the same cycle as the timeout keeps the frame alive.
        abort   = !READ_ENABLE || (!ps2_clk_fall && timeout);

        if (state_q == ST_IDLE || ps2_clk_fall) begin
            to_cnt_d = '0;
        end else if (!timeout) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ps2_clk_fall && READ_ENABLE && !ps2_data_sync) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ps2_clk_fall) begin
                    shift_d   = {ps2_data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ps2_clk_fall) begin
                    parity_err_d = ~(^{shift_q, ps2_data_sync});
                    state_d      = ST_STOP;
                end
            end
            ST_STOP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ps2_clk_fall) begin
                    stop_err_d = ~ps2_data_sync;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                byte_d                = shift_q;
                err_d[ERR_PARITY_BIT] = parity_err_q;
                err_d[ERR_STOP_BIT]   = stop_err_q;
                byte_read_d           = 1'b1;
                state_d               = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            byte_q       <= '0;
            err_q        <= '0;
            byte_read_q  <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_err_q <= parity_err_d;
            stop_err_q   <= stop_err_d;
            byte_q       <= byte_d;
            err_q        <= err_d;
            byte_read_q  <= byte_read_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign BYTE_READ       = byte_read_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE            = byte_q;
    assign BUSY            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver: directed PS/2 frames push expected
// byte/error pairs; a forked monitor pops and compares on every BYTE_READ.
module tb_mouse_receiver;

    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       re = 1'b1;
    logic       byte_read;
    logic [1:0] err_code;
    logic [7:0] byte_o;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    bit         busy_seen = 1'b0;

    mouse_receiver #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .CLK_MOUSE_IN   (ps2_clk),
        .DATA_MOUSE_IN  (ps2_data),
        .READ_ENABLE    (re),
        .BYTE_READ      (byte_read),
        .BYTE_ERROR_CODE(err_code),
        .BYTE           (byte_o),
        .BUSY           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends the first nbits of a frame (start, d[0..7], parity, stop).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input bit expect_read,
                              input logic [7:0] exp_byte, input logic [1:0] exp_err);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        if (expect_read) exp_q.push_back({exp_byte, exp_err});
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (expect_read && i == 10) begin
                repeat (3) @(negedge clk);
                check("latency_early", 32'(byte_read), 32'd0);
                @(negedge clk);
                check("latency_pulse", 32'(byte_read), 32'd1);
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                logic [9:0] e;
                @(negedge clk);
                if (busy) busy_seen = 1'b1;
                if (byte_read) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte_read", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(byte_o), 32'(e[9:2]));
                        check("err_code", 32'(err_code), 32'(e[1:0]));
                    end
                end
            end
        join_none

        repeat (4) @(negedge clk);
        check("rst_byte", 32'(byte_o), 32'h00);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_byte_read", 32'(byte_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Falling edge with data high in IDLE is not a start bit.
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
        repeat (HALF) @(negedge clk);
        check("idle_no_start", 32'(busy), 32'd0);

        send_frame(8'h08, 1'b0, 1'b1, 11, 1'b1, 8'h08, 2'b00);
        send_frame(8'hFA, 1'b0, 1'b1, 11, 1'b1, 8'hFA, 2'b01);
        send_frame(8'h00, 1'b1, 1'b0, 11, 1'b1, 8'h00, 2'b10);

        // Partial frame then silence past the timeout.
        send_frame(8'h3C, 1'b0, 1'b1, 6, 1'b0, 8'h00, 2'b00);
        check("to_busy_mid", 32'(busy), 32'd1);
        repeat (TO + 60) @(negedge clk);
        check("to_busy_drop", 32'(busy), 32'd0);
        check("to_byte_hold", 32'(byte_o), 32'h00);
        check("to_err_hold", 32'(err_code), 32'd2);
        send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b1, 8'hAA, 2'b00);

        // Whole frame while the transmitter owns the bus.
        re = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'h12, 1'b1, 1'b1, 11, 1'b0, 8'h00, 2'b00);
        check("re_low_busy", 32'(busy_seen), 32'd0);
        check("re_low_byte_hold", 32'(byte_o), 32'hAA);
        re = 1'b1;
        repeat (5) @(negedge clk);

        // READ_ENABLE dropping mid-frame aborts.
        send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0, 8'h00, 2'b00);
        check("abort_busy_before", 32'(busy), 32'd1);
        re = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_byte_hold", 32'(byte_o), 32'hAA);
        re = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1'b1, 11, 1'b1, 8'hC3, 2'b00);

        // Reset mid-frame.
        send_frame(8'hF0, 1'b0, 1'b1, 4, 1'b0, 8'h00, 2'b00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_byte", 32'(byte_o), 32'h00);
        check("mid_rst_err", 32'(err_code), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_byte_read", 32'(byte_read), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b1, 11, 1'b1, 8'h55, 2'b00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
